lstm_seq_ctrl: RTL

LSTM_SEQ_CTRL -- requirements
Module: lstm_seq_ctrl

---
 rtl/lstm_pkg.sv | 30 +++
 rtl/lstm_mod_cnt.sv | 44 ++++
 rtl/lstm_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lstm_pkg.sv
// lstm_pkg: shared constants for the LSTM sequence controller.
// Holds the default layer geometry, the controller state encoding and a
// small helper used to form flat weight-ROM addresses.
package lstm_pkg;

    localparam int LSTM_INPUT_SIZE   = 26;   // features per timestep
    localparam int LSTM_ALL_CELL_NUM = 30;   // total LSTM cells
    localparam int LSTM_UNITS_NUM    = 5;    // cells computed in parallel
    localparam int LSTM_TIME_STEP    = 148;  // timesteps per sequence
    localparam int LSTM_ADDR_W       = 8;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_CLR    = 4'd1;
    localparam logic [3:0] ST_LOAD_X = 4'd2;
    localparam logic [3:0] ST_RUN_X  = 4'd3;
    localparam logic [3:0] ST_RUN_H  = 4'd4;
    localparam logic [3:0] ST_WAIT_H = 4'd5;
    localparam logic [3:0] ST_STEP   = 4'd6;
    localparam logic [3:0] ST_FLUSH  = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    // grp*stride + idx in 8-bit unsigned arithmetic; the largest address
    // produced (5*30+29 = 179) stays below 256, so no wrap occurs.
    function automatic logic [7:0] lin_addr(input logic [7:0] grp,
                                            input logic [7:0] stride,
                                            input logic [7:0] idx);
        return (grp * stride) + idx;
    endfunction

endpackage

// File: rtl/lstm_mod_cnt.sv
// lstm_mod_cnt: modulo-MOD index counter.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - synchronous clear to 0 (wins over en)
//   en          - advance by one, wrapping MOD-1 -> 0
//   cnt_q       - registered count
//   cnt_d       - next count (lets the parent register derived values
//                 in step with the counter)
//   tc          - terminal count flag, cnt_q == MOD-1
module lstm_mod_cnt
    import lstm_pkg::*;
#(
    parameter int MOD = 26,
    parameter int W   = LSTM_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt_q,
    output logic [W-1:0] cnt_d,
    output logic         tc
);

    assign tc = (cnt_q == W'(MOD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: sequencer for one LSTM layer over a full input sequence.
// For every timestep it walks the unit groups: feed x (streamed on group 0,
// replayed from the x buffer otherwise), feed previous h, then wait for the
// layer to report the group's h/c. After the last timestep the final h
// vector is streamed out.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - one-cycle request, honoured only when idle
//   f_in_valid          - feature word valid on the input stream
//   h_o_valid           - layer finished the current unit group
//   w_x_en / get_x_en   - stream x into buffer / replay x buffer
//   get_preh_en         - feed previous h
//   addr_x, addr_preh   - x index, previous-h index
//   xw_addr, hw_addr    - input / recurrent weight ROM addresses
//   b_addr, c_addr, addr_h - current unit group
//   h_mem_sel           - H/C ping-pong select
//   prst                - H/C buffer clear pulse
//   h_to_full_en, to_full_h_addr - final h streaming
//   busy, done          - sequence in progress / one-cycle completion
// Every output is a flop, updated on the same edge as the state.
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int INPUT_SIZE   = LSTM_INPUT_SIZE,
    parameter int ALL_CELL_NUM = LSTM_ALL_CELL_NUM,
    parameter int UNITS_NUM    = LSTM_UNITS_NUM,
    parameter int TIME_STEP    = LSTM_TIME_STEP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in_valid,
    input  logic       h_o_valid,
    output logic       w_x_en,
    output logic       get_x_en,
    output logic       get_preh_en,
    output logic [7:0] addr_x,
    output logic [7:0] addr_preh,
    output logic [7:0] xw_addr,
    output logic [7:0] hw_addr,
    output logic [7:0] b_addr,
    output logic [7:0] c_addr,
    output logic [7:0] addr_h,
    output logic       h_mem_sel,
    output logic       prst,
    output logic       h_to_full_en,
    output logic [7:0] to_full_h_addr,
    output logic       busy,
    output logic       done
);

    localparam int         GROUPS   = ALL_CELL_NUM / UNITS_NUM;
    localparam logic [7:0] X_STRIDE = 8'(INPUT_SIZE);
    localparam logic [7:0] H_STRIDE = 8'(ALL_CELL_NUM);

    logic [3:0] state_q, state_d;
    logic       start_idle, wait_hit;
    logic [7:0] x_q, x_d, h_q, h_d, f_q, f_d, g_q, g_d, t_q, t_d;
    logic       x_tc, h_tc, f_tc, g_tc, t_tc;

    logic       w_x_en_q, get_x_en_q, get_preh_en_q, h_to_full_en_q;
    logic       h_mem_sel_q, h_mem_sel_d, prst_q, busy_q, done_q;
    logic [7:0] xw_addr_q, xw_addr_d, hw_addr_q, hw_addr_d;

    assign start_idle = (state_q == ST_IDLE) && start;
    assign wait_hit   = (state_q == ST_WAIT_H) && h_o_valid;

    // Counters wrap to 0 on their last advance, so each phase starts at 0
    // without an explicit clear.
    lstm_mod_cnt #(.MOD(INPUT_SIZE)) u_x_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_idle),
        .en(((state_q == ST_LOAD_X) && f_in_valid) || (state_q == ST_RUN_X)),
        .cnt_q(x_q), .cnt_d(x_d), .tc(x_tc)
    );

    lstm_mod_cnt #(.MOD(ALL_CELL_NUM)) u_h_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_idle),
        .en(state_q == ST_RUN_H),
        .cnt_q(h_q), .cnt_d(h_d), .tc(h_tc)
    );

    lstm_mod_cnt #(.MOD(ALL_CELL_NUM)) u_f_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_idle),
        .en(state_q == ST_FLUSH),
        .cnt_q(f_q), .cnt_d(f_d), .tc(f_tc)
    );

    // Group counter clears on the last group's h_o_valid so that g already
    // reads 0 while in STEP.
    lstm_mod_cnt #(.MOD(GROUPS)) u_g_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_idle || (wait_hit && g_tc)),
        .en(wait_hit && !g_tc),
        .cnt_q(g_q), .cnt_d(g_d), .tc(g_tc)
    );

    lstm_mod_cnt #(.MOD(TIME_STEP)) u_t_cnt (
        .clk(clk), .rst_n(rst_n), .clr(start_idle),
        .en(state_q == ST_STEP),
        .cnt_q(t_q), .cnt_d(t_d), .tc(t_tc)
    );

    // Only the terminal-count flag of the timestep counter is consumed.
    logic unused_t;
    assign unused_t = ^{t_q, t_d};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_CLR;
            ST_CLR:    state_d = ST_LOAD_X;
            ST_LOAD_X: if (f_in_valid && x_tc) state_d = ST_RUN_H;
            ST_RUN_X:  if (x_tc) state_d = ST_RUN_H;
            ST_RUN_H:  if (h_tc) state_d = ST_WAIT_H;
            ST_WAIT_H: if (h_o_valid) state_d = g_tc ? ST_STEP : ST_RUN_X;
            ST_STEP:   state_d = t_tc ? ST_FLUSH : ST_LOAD_X;
            ST_FLUSH:  if (f_tc) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and next counter values so
    // that, once registered, they line up with the state they describe.
    always_comb begin
        h_mem_sel_d = h_mem_sel_q;
        if (start_idle) begin
            h_mem_sel_d = 1'b0;
        end else if ((state_q == ST_WAIT_H) && (state_d == ST_STEP)) begin
            h_mem_sel_d = ~h_mem_sel_q;
        end
        xw_addr_d = lin_addr(g_d, X_STRIDE, x_d);
        hw_addr_d = lin_addr(g_d, H_STRIDE, h_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            w_x_en_q       <= 1'b0;
            get_x_en_q     <= 1'b0;
            get_preh_en_q  <= 1'b0;
            h_to_full_en_q <= 1'b0;
            h_mem_sel_q    <= 1'b0;
            prst_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            xw_addr_q      <= 8'd0;
            hw_addr_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            w_x_en_q       <= (state_d == ST_LOAD_X);
            get_x_en_q     <= (state_d == ST_RUN_X);
            get_preh_en_q  <= (state_d == ST_RUN_H);
            h_to_full_en_q <= (state_d == ST_FLUSH);
            h_mem_sel_q    <= h_mem_sel_d;
            prst_q         <= (state_d == ST_CLR);
            busy_q         <= (state_d != ST_IDLE);
            done_q         <= (state_d == ST_DONE);
            xw_addr_q      <= xw_addr_d;
            hw_addr_q      <= hw_addr_d;
        end
    end

    assign w_x_en         = w_x_en_q;
    assign get_x_en       = get_x_en_q;
    assign get_preh_en    = get_preh_en_q;
    assign h_to_full_en   = h_to_full_en_q;
    assign h_mem_sel      = h_mem_sel_q;
    assign prst           = prst_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign addr_x         = x_q;
    assign addr_preh      = h_q;
    assign to_full_h_addr = f_q;
    assign xw_addr        = xw_addr_q;
    assign hw_addr        = hw_addr_q;
    assign b_addr         = g_q;
    assign c_addr         = g_q;
    assign addr_h         = g_q;

endmodule
